// File: rtl/sys_defs.sv
// Shared execute/complete types and default sizes for the result bus.
// EX_CO_PACKAGE is the bundle carried from the functional units to complete.
package sys_defs;

    localparam int NUM_FU     = 4;
    localparam int CDB_QDEPTH = 2;

    typedef struct packed {
        logic [31:0] NPC;
        logic [31:0] result;
        logic [4:0]  dest_reg_idx;
        logic        take_branch;
        logic        valid;
    } EX_CO_PACKAGE;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-FU result queue: circular head/tail pointers plus an occupancy count.
// clear empties the queue on the same edge and overrides push/pop.
module result_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = CDB_QDEPTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  EX_CO_PACKAGE din,
    output logic         full,
    output logic         empty,
    output EX_CO_PACKAGE head
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    EX_CO_PACKAGE  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    logic          w_hold;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_head];
    assign w_hold = reset || clear;
    assign w_push = push && !full && !w_hold;
    assign w_pop  = pop && !empty && !w_hold;

    always_ff @(posedge clock) begin
        if (w_hold) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= nxt(r_tail);
            if (w_pop)  r_head <= nxt(r_head);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_tail] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: per-FU queues, round-robin pick, registered output.
// Define CDB_BRANCH_PRIORITY_EN to give queue 0 (branch unit) absolute priority.
module cdb_arbiter
    import sys_defs::*;
#(
    parameter int NUM_FU = sys_defs::NUM_FU,
    parameter int QDEPTH = CDB_QDEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic                      co_stall,
    input  logic         [NUM_FU-1:0] fu_valid,
    input  EX_CO_PACKAGE [NUM_FU-1:0] fu_packet,
    output logic         [NUM_FU-1:0] fu_ready,
    output EX_CO_PACKAGE              ex_co_reg
);

`ifdef CDB_BRANCH_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    localparam int RW = ptr_w(NUM_FU);

    logic [RW-1:0]     r_rr_ptr;
    EX_CO_PACKAGE      r_out;
    logic [NUM_FU-1:0] w_full;
    logic [NUM_FU-1:0] w_empty;
    logic [NUM_FU-1:0] w_push;
    logic [NUM_FU-1:0] w_pop;
    EX_CO_PACKAGE      w_head [NUM_FU];
    EX_CO_PACKAGE      w_grant;
    logic              w_load;
    logic              w_found;
    logic [RW-1:0]     w_win;
    logic [RW:0]       w_sum;
    logic [RW-1:0]     w_idx;

    assign w_load    = !r_out.valid || !co_stall;
    assign fu_ready  = reset ? '0 : ~w_full;
    assign ex_co_reg = r_out;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
        assign w_push[g] = fu_valid[g] && fu_ready[g];
        assign w_pop[g]  = w_load && w_found && (w_win == RW'(g));

        result_fifo #(
            .DEPTH(QDEPTH)
        ) u_fifo (
            .clock(clock),
            .reset(reset),
            .clear(squash),
            .push (w_push[g]),
            .pop  (w_pop[g]),
            .din  (fu_packet[g]),
            .full (w_full[g]),
            .empty(w_empty[g]),
            .head (w_head[g])
        );
    end

    // Scan upward from rr_ptr; with priority on, queue 0 is taken first
    // and is otherwise excluded from the rotation.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_sum   = '0;
        w_idx   = '0;
        if (PRIO && !w_empty[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (RW+1)'(k);
            if (w_sum >= (RW+1)'(NUM_FU))
                w_sum = w_sum - (RW+1)'(NUM_FU);
            w_idx = w_sum[RW-1:0];
            if (!w_found && !w_empty[w_idx] &&
                !(PRIO && w_idx == '0)) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_grant       = w_head[w_win];
        w_grant.valid = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out    <= '0;
            r_rr_ptr <= '0;
        end else if (squash) begin
            r_out.valid <= 1'b0;
        end else if (w_load) begin
            if (w_found) begin
                r_out <= w_grant;
                if (!(PRIO && w_win == '0))
                    r_rr_ptr <= (w_win == RW'(NUM_FU - 1)) ?
                                '0 : w_win + RW'(1);
            end else begin
                r_out.valid <= 1'b0;
            end
        end
    end

endmodule
